mem_access_initiator: RTL
=========================

// Module: mem_access_initiator
// PURPOSE
//  Initiator side of the data-memory port. Sits in the MEM stage between the pipeline's
//  load/store request signals and the word-addressed data memory (write_en/read_en/address/
//  input_data -> data). Converts byte addresses to word addresses, holds strobes for a fixed
//  access latency, freezes the pipeline until the access completes, returns registered load data.
// PARAMETERS
//  AW           16      memory word-address width (memory depth = 2**AW words)
//  BASE_ADDR    32'd1024 byte address mapped to memory word 0
//  WAIT_CYCLES  2       extra cycles memory strobes are held after the first (0..15)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  req_rd_en    in   1   pipeline load request (LDR)
//  req_wr_en    in   1   pipeline store request (STR)
//  req_addr     in   32  byte address (ALU result)
//  req_wdata    in   32  store data (Rm value)
//  freeze       out  1   stall pipeline; high while an access is outstanding
//  rdata        out  32  registered load data
//  rdata_valid  out  1   one-cycle pulse: rdata updated
//  mem_rd_en    out  1   memory read strobe
//  mem_wr_en    out  1   memory write strobe
//  mem_addr     out  AW  memory word address
//  mem_wdata    out  32  memory write data
//  mem_rdata    in   32  memory read data (combinational from mem_addr when mem_rd_en)
//  err          out  1   access fault pulse (only with MEM_CHECK_EN; tied 0 otherwise)
// BEHAVIOUR
//  Reset (rst=0, any time incl. mid-access): state IDLE, counter 0, all outputs 0.
//  FSM IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE: on req_rd_en|req_wr_en, latch addr/wdata/kind, go ACCESS; freeze asserted
//   combinationally in this same cycle. Both enables high: treated as store, read ignored.
//  ACCESS: mem_* driven from latched values, strobe held WAIT_CYCLES+1 cycles (counter
//   0..WAIT_CYCLES); freeze high. On last cycle: if load, rdata <= mem_rdata; go DONE.
//  DONE: freeze low, rdata_valid=1 (loads only), strobes low; requests ignored this cycle
//   (same instruction still present); go IDLE.
//  Latency: request cycle + WAIT_CYCLES+1 access cycles + 1 done cycle; freeze high
//   WAIT_CYCLES+2 cycles. Back-to-back requests restart from IDLE.
//  Address: mem_addr = ((req_addr - BASE_ADDR) >> 2)[AW-1:0]; 32-bit subtraction wraps,
//   upper bits discarded. rdata holds its value until the next load completes.
//  mem_wr_en and mem_rd_en never high together; mem_addr/mem_wdata stable while strobed.
// CONFIGURATION
//  MEM_CHECK_EN defined: in IDLE, a request with req_addr[1:0]!=0, req_addr<BASE_ADDR or
//   req_addr>=BASE_ADDR+4*2**AW skips ACCESS: no strobe, go DONE directly; err=1 in DONE,
//   load returns rdata=0 with rdata_valid=1; freeze high only in the request cycle.
//  Undefined: no checks; low two bits dropped, address wraps modulo 2**AW; err tied 0.
// STRUCTURE
//  Package mem_access_pkg: state enum {IDLE, ACCESS, DONE}, CNT_W=4, WORD_SHIFT=2.
//  Single module; no sub-module needed.
// TESTING
//  Load at 0x408, memory[2]=0xDEADBEEF, WAIT_CYCLES=2 -> mem_addr=2, mem_rd_en 3 cycles,
//   freeze 4 cycles, rdata=0xDEADBEEF with rdata_valid pulse.
//  Store 0x12345678 to 0x400 -> mem_wr_en 3 cycles, mem_addr=0, mem_wdata=0x12345678,
//   rdata_valid stays 0.
//  Both enables high at 0x404 -> store only, mem_rd_en never asserted.
//  rst low during 2nd ACCESS cycle -> all outputs 0 immediately; next request starts cleanly.
//  Request held through DONE -> exactly one access; back-to-back load/store -> two accesses.
//  MEM_CHECK_EN: load at 0x406 or 0x3FC -> no strobe, err=1, rdata=0; without -> 0x406 maps to word 1.

Source files
------------

// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
//
// Purpose: shared types and constants for the MEM-stage data-memory
// initiator (mem_access_initiator).
//
// Contents:
//   state_e      - access sequencer states IDLE -> ACCESS -> DONE
//   CNT_W        - width of the strobe-hold counter (covers 0..15)
//   WORD_SHIFT   - byte-to-word address shift for 32-bit words
//   word_offset  - byte address relative to a base, expressed in words
// ---------------------------------------------------------------------------
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int unsigned CNT_W      = 4;
    localparam int unsigned WORD_SHIFT = 2;

    // The subtraction wraps in 32 bits on purpose: addresses below the base
    // land at the top of the word space instead of faulting.
    function automatic logic [31:0] word_offset(input logic [31:0] byte_addr,
                                                input logic [31:0] base);
        logic [31:0] diff;
        diff = byte_addr - base;
        return diff >> WORD_SHIFT;
    endfunction

endpackage

// File: rtl/mem_access_initiator.sv
// ---------------------------------------------------------------------------
// mem_access_initiator
//
// Purpose: initiator side of the pipeline's data-memory port. Accepts a
// load/store request from the MEM stage, translates the byte address into a
// word address, holds the memory strobe for WAIT_CYCLES+1 cycles, stalls the
// pipeline while the access is outstanding and returns registered load data.
//
// Parameters:
//   AW           memory word-address width (depth 2**AW words)
//   BASE_ADDR    byte address that maps onto memory word 0
//   WAIT_CYCLES  extra cycles the strobe is held after the first (0..15)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   req_rd_en    load request from the pipeline
//   req_wr_en    store request from the pipeline (wins if both are high)
//   req_addr     byte address of the access
//   req_wdata    store data
//   freeze       pipeline stall, high while an access is outstanding
//   rdata        registered load data, held until the next load completes
//   rdata_valid  single-cycle pulse when rdata has been updated by a load
//   mem_rd_en    memory read strobe
//   mem_wr_en    memory write strobe
//   mem_addr     memory word address
//   mem_wdata    memory write data
//   mem_rdata    memory read data (combinational from mem_addr)
//   err          access-fault pulse
//
// Configuration:
//   MEM_CHECK_EN  when defined, misaligned or out-of-window requests skip the
//                 memory access, pulse err and return zero for loads. When
//                 undefined, no checks are made and err is tied low.
// ---------------------------------------------------------------------------
module mem_access_initiator
    import mem_access_pkg::*;
#(
    parameter int unsigned AW          = 16,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_rd_en,
    input  logic          req_wr_en,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          freeze,
    output logic [31:0]   rdata,
    output logic          rdata_valid,
    output logic          mem_rd_en,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          err
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              is_store_q, is_store_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              req_any;
    logic              req_fault;

`ifdef MEM_CHECK_EN
    // One bit wider than needed so BASE_ADDR + window size cannot overflow.
    localparam logic [33:0] ADDR_LIMIT = 34'(BASE_ADDR) + (34'd1 << (AW + WORD_SHIFT));

    logic fault_q, fault_d;

    always_comb begin
        req_fault = (req_addr[1:0] != 2'b00)
                 || (req_addr < BASE_ADDR)
                 || (34'(req_addr) >= ADDR_LIMIT);
    end
`else
    always_comb begin
        req_fault = 1'b0;
    end
`endif

    assign req_any = req_rd_en | req_wr_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_store_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_store_q <= is_store_d;
            rdata_q    <= rdata_d;
        end
    end

`ifdef MEM_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        is_store_d  = is_store_q;
        rdata_d     = rdata_q;
        freeze      = 1'b0;
        rdata_valid = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        err         = 1'b0;
`ifdef MEM_CHECK_EN
        fault_d     = fault_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    // The stall must reach the pipeline in the request cycle
                    // itself; gating with rst keeps it low while in reset.
                    freeze     = rst;
                    addr_d     = AW'(word_offset(req_addr, BASE_ADDR));
                    wdata_d    = req_wdata;
                    is_store_d = req_wr_en;
                    cnt_d      = '0;
`ifdef MEM_CHECK_EN
                    fault_d    = req_fault;
`endif
                    if (req_fault) begin
                        state_d = DONE;
                        if (!req_wr_en) begin
                            rdata_d = '0;
                        end
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end

            ACCESS: begin
                freeze    = 1'b1;
                mem_rd_en = ~is_store_q;
                mem_wr_en = is_store_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (!is_store_q) begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                // The pipeline still presents the same instruction here, so
                // requests are deliberately ignored for this one cycle.
                rdata_valid = ~is_store_q;
                state_d     = IDLE;
`ifdef MEM_CHECK_EN
                err         = fault_q;
                fault_d     = 1'b0;
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rdata = rdata_q;

endmodule
